mem_port_arbiter: RTL and testbench

Shares one single-port, 1-cycle-read-latency RAM between the core instruction fetch port and data port. Uses OBI-style req/gnt/rvalid handshakes.
- Fixed priority to instruction fetch, with a starvation guard for data.
- Address range check with error response.
- Pipelined response routing: one grant per cycle, no bubbles.
- Sits between the core and the testbench RAM model; replaces ad-hoc combinational muxing of the two ports.

---
 rtl/mem_arb_pkg.sv | 31 +++
 rtl/mem_arb_starve_ctr.sv | 36 +++
 rtl/mem_port_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared types and constants for the instruction/data memory port arbiter.
//   owner_e   : which requester a response belongs to
//   rsp_t     : response-stage register contents (valid, owner, err)
//   ERR_RDATA : read data returned with error and store responses
//   addr_in_range : RAM window check used on the granted address
package mem_arb_pkg;

  typedef enum logic {
    OWN_INSTR = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
    logic   err;
  } rsp_t;

  localparam logic [31:0] ERR_RDATA = 32'h0;

  // An address hits the RAM when clearing the in-window offset bits leaves
  // exactly the base address. Requires size to be a power of two and base
  // aligned to it.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [31:0] size);
    return (addr & ~(size - 32'd1)) == base;
  endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// mem_arb_starve_ctr
// Counts consecutive cycles in which the data port requests but is refused,
// and raises force_data once that count reaches MAX_WAIT so data overrides
// the fixed instruction priority for one grant.
// Ports:
//   clk_sys, rst_sys : clock, asynchronous active-high reset
//   data_req         : data port is requesting this cycle
//   data_gnt         : data port is granted this cycle
//   force_data       : data must win arbitration this cycle
module mem_arb_starve_ctr #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic clk_sys,
  input  logic rst_sys,
  input  logic data_req,
  input  logic data_gnt,
  output logic force_data
);

  logic [3:0] r_wait_cnt;

  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      r_wait_cnt <= 4'd0;
    end else if (!data_req || data_gnt) begin
      r_wait_cnt <= 4'd0;
    end else if (r_wait_cnt != 4'hF) begin
      // force_data guarantees a grant at MAX_WAIT, so the saturation is
      // only a guard against wrap-around.
      r_wait_cnt <= r_wait_cnt + 4'd1;
    end
  end

  assign force_data = data_req && (r_wait_cnt == 4'(MAX_WAIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port RAM (1-cycle read latency) between the instruction
// fetch port and the data port. Instruction fetch has fixed priority; the
// data port is forced through after MAX_WAIT consecutive refusals.
// Accesses outside [MEM_START, MEM_START+MEM_SIZE) are granted without a RAM
// strobe and answered with an error response.
//
// Handshake (both requester ports): a requester raises *_req with address and
// data stable and keeps them stable until *_gnt is seen high in the same
// cycle; that cycle is the transfer. Exactly one cycle later the owner sees
// *_rvalid with *_rdata/*_err. Only one access is ever in flight.
//
// Ports:
//   clk_sys, rst_sys              : clock, asynchronous active-high reset
//   instr_req/addr, instr_gnt     : fetch request side
//   instr_rvalid/rdata/err        : fetch response side
//   data_req/we/be/addr/wdata     : load/store request side, data_gnt
//   data_rvalid/rdata/err         : load/store response side
//   mem_req/we/be/addr/wdata      : RAM command, mem_rdata : RAM read data
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_SIZE  = 65536,
  parameter logic [31:0] MEM_START = 32'h0000_0000,
  parameter int unsigned MAX_WAIT  = 4,
  localparam int unsigned AW       = $clog2(MEM_SIZE) - 2
) (
  input  logic          clk_sys,
  input  logic          rst_sys,
  input  logic          instr_req,
  input  logic [31:0]   instr_addr,
  output logic          instr_gnt,
  output logic          instr_rvalid,
  output logic [31:0]   instr_rdata,
  output logic          instr_err,
  input  logic          data_req,
  input  logic          data_we,
  input  logic [3:0]    data_be,
  input  logic [31:0]   data_addr,
  input  logic [31:0]   data_wdata,
  output logic          data_gnt,
  output logic          data_rvalid,
  output logic [31:0]   data_rdata,
  output logic          data_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam logic [31:0] SIZE_W = 32'(MEM_SIZE);

  logic        w_force_data;
  logic        w_data_gnt;
  logic        w_instr_gnt;
  logic        w_gnt_any;
  logic [31:0] w_sel_addr;
  logic        w_in_range;
  logic [31:0] w_rsp_rdata;

  rsp_t r_rsp;
  logic r_rsp_store;

  mem_arb_starve_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_ctr (
    .clk_sys    (clk_sys),
    .rst_sys    (rst_sys),
    .data_req   (data_req),
    .data_gnt   (w_data_gnt),
    .force_data (w_force_data)
  );

  // Grants are gated by reset so every output is quiet while reset is held,
  // even though the requests themselves may still be asserted.
  assign w_data_gnt  = !rst_sys && data_req && (!instr_req || w_force_data);
  assign w_instr_gnt = !rst_sys && instr_req && !w_data_gnt;
  assign w_gnt_any   = w_data_gnt || w_instr_gnt;
  assign w_sel_addr  = w_data_gnt ? data_addr : instr_addr;
  assign w_in_range  = addr_in_range(w_sel_addr, MEM_START, SIZE_W);

  assign instr_gnt = w_instr_gnt;
  assign data_gnt  = w_data_gnt;

  // RAM command: driven only for a granted in-range access; fetches never
  // write, so write controls come solely from the data port.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = 32'h0;
    if (w_gnt_any && w_in_range) begin
      mem_req  = 1'b1;
      mem_addr = w_sel_addr[AW+1:2];
      if (w_data_gnt) begin
        mem_we    = data_we;
        mem_be    = data_be;
        mem_wdata = data_wdata;
      end
    end
  end

  // Response stage. valid tracks grants cycle by cycle, which gives
  // back-to-back responses for back-to-back grants. The store flag exists so
  // stores report zero data regardless of what the RAM drives back.
  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      r_rsp       <= '0;
      r_rsp_store <= 1'b0;
    end else begin
      r_rsp.valid <= w_gnt_any;
      if (w_gnt_any) begin
        r_rsp.owner <= w_data_gnt ? OWN_DATA : OWN_INSTR;
        r_rsp.err   <= !w_in_range;
        r_rsp_store <= w_data_gnt && data_we;
      end
    end
  end

  assign w_rsp_rdata = (r_rsp.valid && !r_rsp.err && !r_rsp_store) ? mem_rdata : ERR_RDATA;

  assign instr_rvalid = r_rsp.valid && (r_rsp.owner == OWN_INSTR);
  assign instr_err    = instr_rvalid && r_rsp.err;
  assign instr_rdata  = instr_rvalid ? w_rsp_rdata : 32'h0;

  assign data_rvalid  = r_rsp.valid && (r_rsp.owner == OWN_DATA);
  assign data_err     = data_rvalid && r_rsp.err;
  assign data_rdata   = data_rvalid ? w_rsp_rdata : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed scenarios followed by randomized traffic, checked each cycle
// against a transaction-level reference model of the arbiter and RAM.
module tb_mem_port_arbiter;

  localparam int MEM_SIZE = 65536;
  localparam int MAX_WAIT = 4;
  localparam int AW       = 14;
  localparam int WORDS    = MEM_SIZE / 4;

  // ---------------- clock / reset ----------------
  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;
  logic rst_sys;

  // ---------------- main DUT (MEM_START = 0) ----------------
  logic          instr_req, instr_gnt, instr_rvalid, instr_err;
  logic [31:0]   instr_addr, instr_rdata;
  logic          data_req, data_we, data_gnt, data_rvalid, data_err;
  logic [3:0]    data_be;
  logic [31:0]   data_addr, data_wdata, data_rdata;
  logic          mem_req, mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = 32'h0;

  mem_port_arbiter #(
    .MEM_SIZE (MEM_SIZE), .MEM_START (32'h0000_0000), .MAX_WAIT (MAX_WAIT)
  ) u_dut (
    .clk_sys (clk_sys), .rst_sys (rst_sys),
    .instr_req (instr_req), .instr_addr (instr_addr), .instr_gnt (instr_gnt),
    .instr_rvalid (instr_rvalid), .instr_rdata (instr_rdata), .instr_err (instr_err),
    .data_req (data_req), .data_we (data_we), .data_be (data_be),
    .data_addr (data_addr), .data_wdata (data_wdata), .data_gnt (data_gnt),
    .data_rvalid (data_rvalid), .data_rdata (data_rdata), .data_err (data_err),
    .mem_req (mem_req), .mem_we (mem_we), .mem_be (mem_be), .mem_addr (mem_addr),
    .mem_wdata (mem_wdata), .mem_rdata (mem_rdata)
  );

  // ---------------- second DUT (MEM_START = 0x8000_0000) ----------------
  logic          h_instr_req, h_instr_gnt, h_instr_rvalid, h_instr_err;
  logic [31:0]   h_instr_addr, h_instr_rdata;
  logic          h_data_gnt, h_data_rvalid, h_data_err;
  logic [31:0]   h_data_rdata;
  logic          h_mem_req, h_mem_we;
  logic [3:0]    h_mem_be;
  logic [AW-1:0] h_mem_addr;
  logic [31:0]   h_mem_wdata;
  logic          h_zero1 = 1'b0;
  logic [3:0]    h_zero4 = 4'h0;
  logic [31:0]   h_zero32 = 32'h0;
  logic [31:0]   h_mem_rdata = 32'hA5A5_A5A5;

  mem_port_arbiter #(
    .MEM_SIZE (MEM_SIZE), .MEM_START (32'h8000_0000), .MAX_WAIT (MAX_WAIT)
  ) u_dut_hi (
    .clk_sys (clk_sys), .rst_sys (rst_sys),
    .instr_req (h_instr_req), .instr_addr (h_instr_addr), .instr_gnt (h_instr_gnt),
    .instr_rvalid (h_instr_rvalid), .instr_rdata (h_instr_rdata), .instr_err (h_instr_err),
    .data_req (h_zero1), .data_we (h_zero1), .data_be (h_zero4),
    .data_addr (h_zero32), .data_wdata (h_zero32), .data_gnt (h_data_gnt),
    .data_rvalid (h_data_rvalid), .data_rdata (h_data_rdata), .data_err (h_data_err),
    .mem_req (h_mem_req), .mem_we (h_mem_we), .mem_be (h_mem_be), .mem_addr (h_mem_addr),
    .mem_wdata (h_mem_wdata), .mem_rdata (h_mem_rdata)
  );

  // ---------------- RAM behavioural model ----------------
  logic [31:0] ram [WORDS];
  always @(posedge clk_sys) begin
    if (mem_req) begin
      mem_rdata <= ram[mem_addr];
      if (mem_we)
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] shadow [WORDS];   // expected RAM contents
  int          m_refused;        // consecutive refused data cycles
  bit          m_v, m_own, m_err;
  logic [31:0] m_rdata;
  bit          g_i, g_d;         // model's grant decision of the last step
  logic [31:0] exp_q[$];         // expected response data, one per grant

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ignt"},  32'(instr_gnt), 32'h0);
    chk({tag, "_dgnt"},  32'(data_gnt), 32'h0);
    chk({tag, "_ivld"},  32'(instr_rvalid), 32'h0);
    chk({tag, "_dvld"},  32'(data_rvalid), 32'h0);
    chk({tag, "_ierr"},  32'(instr_err), 32'h0);
    chk({tag, "_derr"},  32'(data_err), 32'h0);
    chk({tag, "_irdat"}, instr_rdata, 32'h0);
    chk({tag, "_drdat"}, data_rdata, 32'h0);
    chk({tag, "_mreq"},  {31'h0, mem_req} | {31'h0, mem_we} | {28'h0, mem_be}, 32'h0);
    chk({tag, "_maddr"}, 32'(mem_addr) | mem_wdata, 32'h0);
  endtask

  // The RAM window is [0, MEM_SIZE) for the main instance.
  function automatic bit in_window(input logic [31:0] a);
    return a < 32'(MEM_SIZE);
  endfunction

  // One cycle: inputs are already driven (just after a falling edge).
  task automatic step();
    bit          dw, ig, ok;
    logic [31:0] a;
    int          w;
    #1;
    // response to whatever was granted in the previous cycle
    chk("instr_rvalid", 32'(instr_rvalid), 32'(m_v && !m_own));
    chk("data_rvalid",  32'(data_rvalid),  32'(m_v && m_own));
    chk("instr_err",    32'(instr_err),    32'(m_v && !m_own && m_err));
    chk("data_err",     32'(data_err),     32'(m_v && m_own && m_err));
    chk("instr_rdata",  instr_rdata, (m_v && !m_own) ? m_rdata : 32'h0);
    chk("data_rdata",   data_rdata,  (m_v && m_own) ? m_rdata : 32'h0);
    // arbitration for this cycle
    dw = data_req && (!instr_req || m_refused == MAX_WAIT);
    ig = instr_req && !dw;
    a  = dw ? data_addr : instr_addr;
    ok = in_window(a);
    w  = ok ? int'(a) / 4 : 0;
    chk("instr_gnt", 32'(instr_gnt), 32'(ig));
    chk("data_gnt",  32'(data_gnt),  32'(dw));
    chk("mem_req",   32'(mem_req),   32'((ig || dw) && ok));
    chk("mem_we",    32'(mem_we),    32'(dw && ok && data_we));
    chk("mem_be",    32'(mem_be),    (dw && ok) ? 32'(data_be) : 32'h0);
    chk("mem_addr",  32'(mem_addr),  ((ig || dw) && ok) ? 32'(w) : 32'h0);
    chk("mem_wdata", mem_wdata,      (dw && ok) ? data_wdata : 32'h0);
    // advance the model
    if (dw) m_refused = 0;
    else if (data_req) m_refused++;
    else m_refused = 0;
    m_v = ig || dw;
    if (m_v) begin
      m_own   = dw;
      m_err   = !ok;
      m_rdata = (!ok || (dw && data_we)) ? 32'h0 : shadow[w];
      if (ok && dw && data_we)
        for (int b = 0; b < 4; b++)
          if (data_be[b]) shadow[w][8*b +: 8] = data_wdata[8*b +: 8];
    end
    g_i = ig;
    g_d = dw;
    @(negedge clk_sys);
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return 32'h0001_0000 | $urandom;
    return 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(0, 3));
  endfunction

  // ---------------- directed + random sequence ----------------
  bit i_pend, d_pend;

  initial begin
    for (int i = 0; i < WORDS; i++) begin
      ram[i]    = {16'hC0DE, 16'(i)};
      shadow[i] = {16'hC0DE, 16'(i)};
    end
    instr_req = 0; instr_addr = 0; data_req = 0; data_we = 0; data_be = 0;
    data_addr = 0; data_wdata = 0; h_instr_req = 0; h_instr_addr = 0;
    m_refused = 0; m_v = 0; m_own = 0; m_err = 0; m_rdata = 0;

    // reset: outputs quiet even with requests asserted
    rst_sys = 1;
    @(negedge clk_sys);
    instr_req = 1; data_req = 1; instr_addr = 32'h10; data_addr = 32'h20;
    #1 chk_quiet("reset");
    @(negedge clk_sys);
    instr_req = 0; data_req = 0; rst_sys = 0;

    // fetch at 0x10 -> word 4
    instr_req = 1; instr_addr = 32'h10;
    #1 chk("fetch_maddr", 32'(mem_addr), 32'd4);
    step();
    instr_req = 0;
    #1 chk("fetch_rdata", instr_rdata, 32'hC0DE_0004);
    step();

    // half-word store then load of the same word
    data_req = 1; data_we = 1; data_be = 4'b0011; data_addr = 32'h20; data_wdata = 32'hDEAD_BEEF;
    step();
    data_we = 0; data_be = 4'b1111;
    step();
    data_req = 0;
    #1 chk("load_merge", data_rdata, 32'hC0DE_BEEF);
    step();

    // zero byte-enable store still strobes the RAM
    data_req = 1; data_we = 1; data_be = 4'b0000; data_addr = 32'h24; data_wdata = 32'hFFFF_FFFF;
    #1 chk("be0_mreq", {31'h0, mem_req} | {30'h0, mem_we, 1'b0}, 32'h3);
    step();
    data_req = 0;
    step();

    // both ports held: four fetches then one data grant, repeated
    instr_req = 1; instr_addr = 32'h30; data_req = 1; data_we = 0; data_addr = 32'h40;
    for (int k = 0; k < 10; k++) begin
      #1 chk("starve_dgnt", 32'(data_gnt), 32'(k % 5 == 4));
      instr_addr = 32'(k) * 4;
      step();
    end
    instr_req = 0; data_req = 0;
    step();

    // out-of-range load
    data_req = 1; data_we = 0; data_addr = 32'h0001_0000;
    #1 chk("oor_mreq", 32'(mem_req), 32'h0);
    step();
    data_req = 0;
    #1 chk("oor_err", {30'h0, data_rvalid, data_err}, 32'h3);
    step();

    // asynchronous reset while a response is pending
    instr_req = 1; instr_addr = 32'h14;
    step();
    data_req = 1; data_addr = 32'h8;
    #1 rst_sys = 1;
    #1 chk_quiet("async_rst");
    m_v = 0; m_refused = 0;
    @(negedge clk_sys);
    @(negedge clk_sys);
    rst_sys = 0; data_req = 0; instr_req = 1; instr_addr = 32'h18;
    step();
    instr_req = 0;
    #1 chk("post_rst_rdata", instr_rdata, 32'hC0DE_0006);
    step();

    // non-zero RAM base
    h_instr_req = 1; h_instr_addr = 32'h8000_0008;
    #1 chk("hi_gnt", {30'h0, h_instr_gnt, h_mem_req}, 32'h3);
    chk("hi_maddr", 32'(h_mem_addr), 32'd2);
    step();
    h_instr_addr = 32'h0000_0008;
    #1 chk("hi_rsp", {30'h0, h_instr_rvalid, h_instr_err}, 32'h2);
    chk("hi_rdata", h_instr_rdata, 32'hA5A5_A5A5);
    chk("hi_oor_mreq", {30'h0, h_instr_gnt, h_mem_req}, 32'h2);
    step();
    h_instr_req = 0;
    #1 chk("hi_oor_rsp", {30'h0, h_instr_rvalid, h_instr_err}, 32'h3);
    chk("hi_oor_rdata", h_instr_rdata, 32'h0);
    step();

    // randomized traffic; requesters hold their request until granted
    i_pend = 0; d_pend = 0;
    for (int n = 0; n < 400; n++) begin
      if (!i_pend && $urandom_range(0, 9) < 7) begin
        i_pend = 1; instr_addr = rand_addr();
      end
      if (!d_pend && $urandom_range(0, 9) < 5) begin
        d_pend = 1; data_addr = rand_addr(); data_we = 1'($urandom_range(0, 1));
        data_be = 4'($urandom_range(0, 15)); data_wdata = $urandom;
      end
      instr_req = i_pend; data_req = d_pend;
      step();
      if (g_i) i_pend = 0;
      if (g_d) d_pend = 0;
    end
    instr_req = 0; data_req = 0;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
